// File: rtl/frame_feeder.sv
// Circular sample buffer that assembles overlapping frames and serves them
// to the windowing stage over a start/read/done handshake.
module frame_feeder #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FRAME_LEN    = 306,
    parameter int HOP_LEN      = 153,
    parameter int BUF_DEPTH    = 512
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
    input  logic                           sample_valid_i,
    output logic                           start_o,
    input  logic                           rd_en_i,
    output logic                           valid_to_read_o,
    output logic signed [SAMPLE_WIDTH-1:0] frame_sample_o,
    input  logic                           consumer_done_i,
    output logic                           overflow_o,
    output logic [15:0]                    frame_cnt_o
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int SW = $clog2(FRAME_LEN + 1);

    localparam logic [AW:0]   DEPTH_C     = (AW+1)'(BUF_DEPTH);
    localparam logic [AW:0]   FRAME_C     = (AW+1)'(FRAME_LEN);
    localparam logic [AW:0]   HOP_AVAIL_C = (AW+1)'(HOP_LEN);
    localparam logic [AW-1:0] HOP_PTR_C   = AW'(HOP_LEN);
    localparam logic [SW-1:0] LAST_BEAT_C = SW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        SERVE,
        WAIT_DONE
    } state_t;

    state_t state, state_next;

    logic signed [SAMPLE_WIDTH-1:0] mem [BUF_DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] frame_base;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   avail;
    logic [SW-1:0] served;
    logic          wr_accept;
    logic          do_read;
    logic          release_hop;
    logic          last_beat;

    // A full buffer refuses writes, which is what protects the frame being served.
    assign wr_accept = sample_valid_i && (avail != DEPTH_C);
    assign rd_addr   = frame_base + AW'(served);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (avail >= FRAME_C) state_next = START;
            START:     state_next = SERVE;
            SERVE:     if (last_beat) state_next = WAIT_DONE;
            WAIT_DONE: if (consumer_done_i) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        start_o     = (state == START);
        do_read     = (state == SERVE) && rd_en_i;
        release_hop = (state == WAIT_DONE) && consumer_done_i;
        last_beat   = do_read && (served == LAST_BEAT_C);
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= sample_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            avail      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (sample_valid_i && !wr_accept) begin
                overflow_o <= 1'b1;
            end
            avail <= avail + {{AW{1'b0}}, wr_accept} - (release_hop ? HOP_AVAIL_C : '0);
        end
    end

    // Read side: served counts beats of the current frame, frame_base moves on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            served          <= '0;
            valid_to_read_o <= 1'b0;
            frame_sample_o  <= '0;
            frame_cnt_o     <= '0;
            frame_base      <= '0;
        end else begin
            if (state == IDLE) begin
                served <= '0;
            end else if (do_read) begin
                served <= served + SW'(1);
            end
            valid_to_read_o <= do_read;
            if (do_read) begin
                frame_sample_o <= mem[rd_addr];
            end
            if (last_beat) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end
            if (release_hop) begin
                frame_base <= frame_base + HOP_PTR_C;
            end
        end
    end

endmodule

// File: tb/tb_frame_feeder.sv
// Directed bench for frame_feeder: table of frame transactions plus hand-built
// overflow and mid-frame reset sequences.
module tb_frame_feeder;

    localparam int FRAME_LEN = 306;

    logic        clk;
    logic        rst_n;
    logic [15:0] sample;
    logic        sample_valid;
    logic        start;
    logic        rd_en;
    logic        valid;
    logic [15:0] frame_sample;
    logic        consumer_done;
    logic        overflow;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int next_val = 0;

    typedef struct {
        int n_push;
        int exp_first;
        bit gapped;
        int exp_cnt;
    } frame_vec_t;

    frame_vec_t vecs [4];

    frame_feeder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sample_i        (sample),
        .sample_valid_i  (sample_valid),
        .start_o         (start),
        .rd_en_i         (rd_en),
        .valid_to_read_o (valid),
        .frame_sample_o  (frame_sample),
        .consumer_done_i (consumer_done),
        .overflow_o      (overflow),
        .frame_cnt_o     (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            if (errors <= 40)
                $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic resetDut();
        rst_n         = 1'b0;
        sample        = '0;
        sample_valid  = 1'b0;
        rd_en         = 1'b0;
        consumer_done = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_start", start, 0);
        checkOutput("reset_valid", valid, 0);
        checkOutput("reset_sample", frame_sample, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;
    endtask

    task automatic push(input int first_val, input int n, input bit chk_no_start);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (chk_no_start) checkOutput("no_early_start", start, 0);
            sample       = 16'(first_val + i);
            sample_valid = 1'b1;
        end
        @(negedge clk);
        if (chk_no_start) checkOutput("no_early_start", start, 0);
        sample_valid = 1'b0;
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (start) seen = 1'b1;
        end
        checkOutput("start_pulse", seen, 1);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        consumer_done = 1'b1;
        @(negedge clk);
        consumer_done = 1'b0;
        checkOutput("start_after_done", start, 0);
    endtask

    // Every beat must follow a sampled rd_en, and the values must run contiguously from first.
    task automatic read_frame(input int first, input bit gapped, input int exp_cnt);
        int got = 0;
        int cyc = 0;
        int phase = 0;
        bit prev = 1'b0;
        bit rd;
        while (got < FRAME_LEN && cyc < 4 * FRAME_LEN + 16) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) checkOutput("start_single_pulse", start, 0);
            if (prev) begin
                checkOutput("beat_valid", valid, 1);
                checkOutput("beat_data", frame_sample, 16'(first + got));
                got++;
            end else begin
                checkOutput("no_beat_valid", valid, 0);
            end
            rd = gapped ? ((phase % 4 == 0) || (phase % 4 == 3)) : 1'b1;
            phase++;
            if (got >= FRAME_LEN) rd = 1'b0;
            rd_en = rd;
            prev  = rd;
        end
        checkOutput("frame_complete", got, FRAME_LEN);
        checkOutput("frame_cnt", frame_cnt, exp_cnt);
        rd_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("extra_rd_ignored", valid, 0);
        end
        rd_en = 1'b0;
    endtask

    task automatic applyStimulus(input frame_vec_t v);
        push(next_val, v.n_push, 1'b1);
        next_val += v.n_push;
        wait_start(3);
        read_frame(v.exp_first, v.gapped, v.exp_cnt);
        pulse_done();
    endtask

    initial begin
        vecs[0] = '{306, 0,   1'b0, 1};
        vecs[1] = '{153, 153, 1'b0, 2};
        vecs[2] = '{153, 306, 1'b1, 3};
        vecs[3] = '{153, 459, 1'b0, 4};

        $display("[TB] frame sequence across buffer wrap");
        resetDut();
        next_val = 0;
        for (int k = 0; k < 4; k++) applyStimulus(vecs[k]);

        $display("[TB] overflow with consumer stalled");
        resetDut();
        push(0, 512, 1'b0);
        checkOutput("overflow_before_full", overflow, 0);
        push(512, 88, 1'b0);
        checkOutput("overflow_set", overflow, 1);
        read_frame(0, 1'b0, 1);
        pulse_done();
        wait_start(1);
        read_frame(153, 1'b0, 2);
        checkOutput("overflow_sticky", overflow, 1);
        pulse_done();

        $display("[TB] reset in the middle of a frame");
        resetDut();
        push(1000, 306, 1'b1);
        wait_start(3);
        @(negedge clk);
        rd_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checkOutput("pre_reset_valid", valid, 1);
            checkOutput("pre_reset_data", frame_sample, 16'(1000 + i));
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", valid, 0);
        checkOutput("midreset_start", start, 0);
        checkOutput("midreset_frame_cnt", frame_cnt, 0);
        checkOutput("midreset_sample", frame_sample, 0);
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push(2000, 305, 1'b1);
        repeat (4) begin
            @(negedge clk);
            checkOutput("post_reset_no_start", start, 0);
        end
        push(2305, 1, 1'b1);
        wait_start(3);
        read_frame(2000, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
